uart_tx: RTL and testbench

Serial UART transmitter that sits directly downstream of the PC-link byte framer. It accepts one byte per `txen` strobe and shifts it out on a single line as 8N1: one start bit, eight data bits LSB-first, one stop bit. A one-byte holding register lets a new strobe arrive while a frame is still on the line, so consecutive bytes go out back-to-back.

---
 rtl/uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txen,
  input  logic [7:0] txdata,
  input  logic       ovr_clr,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic [7:0]    r_shift;
  logic [7:0]    w_nshift;
  logic [7:0]    r_hold;
  logic [7:0]    w_nhold;
  logic          r_hv;
  logic          w_nhv;
  logic [2:0]    r_idx;
  logic [2:0]    w_nidx;
  logic          r_ovr;
  logic          w_novr;
  logic          r_tx;
  logic          w_ntx;
  logic          r_busy;
  logic          r_done;
  logic          w_bit_end;
  logic          w_direct;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
  logic          w_npar;
`endif

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_ovr;

  assign w_bit_end = (r_cnt == LAST);
  // a strobe on the last stop cycle with nothing held loads directly
  assign w_direct  = (r_state == STOP) && w_bit_end && !r_hv;

  // state and datapath registers; outputs register the next-state view
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_hv    <= 1'b0;
      r_idx   <= '0;
      r_ovr   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_shift <= w_nshift;
      r_hold  <= w_nhold;
      r_hv    <= w_nhv;
      r_idx   <= w_nidx;
      r_ovr   <= w_novr;
      r_tx    <= w_ntx;
      r_busy  <= (w_nstate != IDLE) || w_nhv;
      r_done  <= (w_nstate == STOP) && (w_ncnt == LAST);
`ifdef UART_TX_PARITY_EN
      r_par   <= w_npar;
`endif
    end
  end

  // next-state, datapath update and holding-register capture
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nshift = r_shift;
    w_nhold  = r_hold;
    w_nhv    = r_hv;
    w_nidx   = r_idx;
    w_novr   = r_ovr;
`ifdef UART_TX_PARITY_EN
    w_npar   = r_par;
`endif
    if (r_state != IDLE) begin
      w_ncnt = w_bit_end ? '0 : r_cnt + 1'b1;
    end
    unique case (r_state)
      IDLE: begin
        if (txen) begin
          w_nstate = START;
          w_nshift = txdata;
          w_ncnt   = '0;
        end
      end
      START: begin
        w_nidx = '0;
`ifdef UART_TX_PARITY_EN
        w_npar = 1'b0;
`endif
        if (w_bit_end) w_nstate = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_nshift = r_shift >> 1;
          w_nidx   = r_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
          w_npar   = r_par ^ r_shift[0];
          if (r_idx == 3'd7) w_nstate = PARITY;
`else
          if (r_idx == 3'd7) w_nstate = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) w_nstate = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_hv) begin
            w_nstate = START;
            w_nshift = r_hold;
            w_nhv    = 1'b0;
          end else if (txen) begin
            w_nstate = START;
            w_nshift = txdata;
          end else begin
            w_nstate = IDLE;
          end
        end
      end
      default: w_nstate = IDLE;
    endcase
    if (ovr_clr) w_novr = 1'b0;
    if (txen && (r_state != IDLE) && !w_direct) begin
      if (!r_hv) begin
        w_nhold = txdata;
        w_nhv   = 1'b1;
      end else begin
        w_novr  = 1'b1;
      end
    end
  end

  // line level for the cycle after the next edge
  always_comb begin
    w_ntx = 1'b1;
    unique case (w_nstate)
      IDLE:   w_ntx = 1'b1;
      START:  w_ntx = 1'b0;
      DATA:   w_ntx = w_nshift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: w_ntx = w_npar;
`endif
      STOP:   w_ntx = 1'b1;
      default: w_ntx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a line-decoding
// scoreboard; CLKS_PER_BIT = 8.
module tb_uart_tx;

  localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FL = (10 + NPAR) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       txen;
  logic [7:0] txdata;
  logic       ovr_clr;
  logic       tx;
  logic       busy;
  logic       done;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .txen    (txen),
    .txdata  (txdata),
    .ovr_clr (ovr_clr),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d got %0h expected %0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      txen    = 1'b0;
      ovr_clr = 1'b0;
    end
  endtask

  task automatic strobe(input logic [7:0] b, input bit expect_out);
    txen   = 1'b1;
    txdata = b;
    if (expect_out) sb.push_back(b);
  endtask

  function automatic logic exp_tx(input int c, input logic [7:0] b);
    if (c >= 1 && c <= CPB) return 1'b0;
    if (c > CPB && c <= 9 * CPB) return b[(c - CPB - 1) / CPB];
    if (NPAR == 1 && c > 9 * CPB && c <= 10 * CPB) return ^b;
    return 1'b1;
  endfunction

  // one byte from idle, checked cycle by cycle through busy release
  task automatic send_single(input logic [7:0] b);
    strobe(b, 1'b1);
    cyc = 0;
    adv(1);
    for (int c = 1; c <= FL + 1; c++) begin
      chk("single_tx", 8'(tx), 8'(exp_tx(c, b)));
      chk("single_done", 8'(done), 8'(c == FL));
      chk("single_busy", 8'(busy), 8'(c <= FL));
      if (c <= FL) adv(1);
    end
  endtask

  // line receiver: samples mid-bit, pops the scoreboard per frame
  task automatic mwait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst !== 1'b1) ab = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] e;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        d  = '0;
        mwait(CPB / 2, ab);
        if (tx !== 1'b0) ab = 1'b1;
        for (int i = 0; i < 8; i++) begin
          mwait(CPB, ab);
          d[i] = tx;
        end
        if (NPAR == 1) begin
          mwait(CPB, ab);
          if (!ab) chk("mon_parity", 8'(tx), 8'(^d));
        end
        mwait(CPB, ab);
        if (!ab) begin
          chk("mon_stop", 8'(tx), 8'd1);
          if (sb.size() == 0) begin
            chk("mon_unexpected", d, 8'hxx);
          end else begin
            e = sb.pop_front();
            chk("mon_byte", d, e);
          end
        end
      end
    end
  end

  initial begin
    int ndone;
    rst     = 1'b0;
    txen    = 1'b0;
    txdata  = 8'h00;
    ovr_clr = 1'b0;

    // reset with strobes toggling
    for (int i = 0; i < 3; i++) begin
      txen   = (i % 2 == 0);
      txdata = 8'hFF;
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_tx", 8'(tx), 8'd1);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_ovr", 8'(overrun), 8'd0);
    end
    txen = 1'b0;
    rst  = 1'b1;
    adv(3);
    chk("post_rst_tx", 8'(tx), 8'd1);

    // single byte
`ifdef UART_TX_PARITY_EN
    send_single(8'h07);
`else
    send_single(8'hA5);
`endif
    adv(10);

    // back-to-back via holding register
    strobe(8'h55, 1'b1);
    cyc = 0;
    adv(5);
    strobe(8'h0F, 1'b1);
    ndone = 0;
    for (int c = 5; c <= 2 * FL + 1; c++) begin
      if (done === 1'b1) ndone++;
      if (c == FL) chk("b2b_done1", 8'(done), 8'd1);
      if (c > FL - CPB && c <= FL)
        chk("b2b_stop1", 8'(tx), 8'd1);
      if (c > FL && c <= FL + CPB)
        chk("b2b_start2", 8'(tx), 8'd0);
      if (c == FL + 1) chk("b2b_busy", 8'(busy), 8'd1);
      if (c == 2 * FL) chk("b2b_done2", 8'(done), 8'd1);
      if (c == 2 * FL + 1) chk("b2b_idle", 8'(busy), 8'd0);
      if (c <= 2 * FL) adv(1);
    end
    chk("b2b_ndone", 8'(ndone), 8'd2);
    adv(10);

    // overrun: third strobe dropped
    strobe(8'h11, 1'b1);
    cyc = 0;
    adv(2);
    strobe(8'h22, 1'b1);
    adv(2);
    chk("ovr_before", 8'(overrun), 8'd0);
    strobe(8'h33, 1'b0);
    adv(1);
    chk("ovr_set", 8'(overrun), 8'd1);
    adv(195);
    chk("ovr_hold", 8'(overrun), 8'd1);
    ovr_clr = 1'b1;
    adv(1);
    chk("ovr_clr", 8'(overrun), 8'd0);
    chk("ovr_idle", 8'(busy), 8'd0);
    adv(10);

    // reset mid-frame with a byte held
    strobe(8'h3C, 1'b0);
    cyc = 0;
    adv(2);
    strobe(8'hC3, 1'b0);
    adv(28);
    chk("mid_busy_pre", 8'(busy), 8'd1);
    rst = 1'b0;
    adv(1);
    chk("mid_tx", 8'(tx), 8'd1);
    chk("mid_busy", 8'(busy), 8'd0);
    chk("mid_done", 8'(done), 8'd0);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      adv(1);
      if (done !== 1'b0 || tx !== 1'b1) ndone++;
    end
    chk("mid_quiet", 8'(ndone), 8'd0);

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
